// File: rtl/mcd_pkg.sv
// Shared types for the sub-CPU DMA path: the McdDma bus payload seen by the
// Word RAM controller and PRG/PCM arbiters, destination codes, FSM states.
package mcd_pkg;

  localparam int unsigned MCD_ADDR_W = 19;  // byte-address width of McdDma.addr
  localparam int unsigned MCD_LEN_W  = 12;  // byte-count register width
  localparam int unsigned MCD_PCM_AW = 13;  // PCM RAM window (8 KB wrap)
  localparam int unsigned MCD_DEST_W = 3;

  localparam logic [MCD_DEST_W-1:0] DST_PCM  = 3'd4;
  localparam logic [MCD_DEST_W-1:0] DST_PRG  = 3'd5;
  localparam logic [MCD_DEST_W-1:0] DST_WRAM = 3'd7;

  typedef struct packed {
    logic                  ce_wram;
    logic                  ce_prg;
    logic                  ce_pcm;
    logic                  we;
    logic [MCD_ADDR_W-1:0] addr;
    logic [15:0]           dat;
  } McdDma;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WRITE = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } dma_state_e;

  // True when the destination code selects a real memory target.
  function automatic logic dst_valid(input logic [MCD_DEST_W-1:0] d);
    return (d == DST_PCM) || (d == DST_PRG) || (d == DST_WRAM);
  endfunction

endpackage

// File: rtl/mcd_dma_addr_gen.sv
// DMA destination address generator: forms the start byte address from the
// address register and steps it by one word, wrapping inside the full
// ADDR_W space (WRAM/PRG) or inside the PCM_AW window (PCM).
// Ports:
//   clk_asic, cd_rst  - clock, synchronous active-high reset
//   i_en              - clock enable (sub_sync)
//   i_load            - load start address and remember PCM-ness of i_dest
//   i_inc             - advance the address by 2 bytes
//   i_dest            - destination code sampled on i_load
//   i_addr_reg        - destination address register
//   o_addr            - current byte address (registered)
module mcd_dma_addr_gen
  import mcd_pkg::*;
#(
  parameter int unsigned ADDR_W = MCD_ADDR_W,
  parameter int unsigned PCM_AW = MCD_PCM_AW
) (
  input  logic                  clk_asic,
  input  logic                  cd_rst,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic                  i_inc,
  input  logic [MCD_DEST_W-1:0] i_dest,
  input  logic [15:0]           i_addr_reg,
  output logic [ADDR_W-1:0]     o_addr
);

  logic              r_pcm;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_start;
  logic [ADDR_W-1:0] w_inc;

  // Start address: register is in 8-byte units for WRAM/PRG, 2-byte units for PCM.
  always_comb begin
    w_start = ADDR_W'({i_addr_reg, 3'b000});
    if (i_dest == DST_PCM) begin
      w_start = ADDR_W'({i_addr_reg[PCM_AW-2:0], 1'b0});
    end
  end

  // Word step; PCM wraps inside its window leaving the upper bits alone.
  always_comb begin
    w_inc = r_addr + ADDR_W'(2);
    if (r_pcm) begin
      w_inc = {r_addr[ADDR_W-1:PCM_AW], r_addr[PCM_AW-1:0] + PCM_AW'(2)};
    end
  end

  always_ff @(posedge clk_asic) begin
    if (cd_rst) begin
      r_addr <= '0;
      r_pcm  <= 1'b0;
    end else if (i_en) begin
      if (i_load) begin
        r_addr <= w_start;
        r_pcm  <= (i_dest == DST_PCM);
      end else if (i_inc) begin
        r_addr <= w_inc;
      end
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/mcd_cdc_dma.sv
// CDC-to-memory DMA initiator for the sub-CPU side. Pulls 16-bit words from
// the CDC host buffer and writes them to Word RAM, PRG RAM or PCM RAM through
// the McdDma bus, stalling on halt. Advances only on sub_sync.
// Ports:
//   clk_asic, cd_rst         - clock, synchronous active-high reset
//   sub_sync                 - sub-CPU clock enable
//   start, stop              - kick / abort pulses from the register file
//   dest, dma_addr_reg, dbc  - destination code, address register, bytes-1
//   buf_rd_req/ack/dat       - CDC buffer read handshake
//   halt                     - memory side not ready, hold the write
//   dma                      - memory request bus (McdDma)
//   busy, done               - DSR flag and one-tick EDT pulse
// ADDR_W must match MCD_ADDR_W, the width carried by McdDma.addr.
module mcd_cdc_dma
  import mcd_pkg::*;
#(
  parameter int unsigned ADDR_W = MCD_ADDR_W,
  parameter int unsigned LEN_W  = MCD_LEN_W,
  parameter int unsigned PCM_AW = MCD_PCM_AW
) (
  input  logic                  clk_asic,
  input  logic                  cd_rst,
  input  logic                  sub_sync,
  input  logic                  start,
  input  logic                  stop,
  input  logic [MCD_DEST_W-1:0] dest,
  input  logic [15:0]           dma_addr_reg,
  input  logic [LEN_W-1:0]      dbc,
  output logic                  buf_rd_req,
  input  logic                  buf_rd_ack,
  input  logic [15:0]           buf_rd_dat,
  input  logic                  halt,
  output McdDma                 dma,
  output logic                  busy,
  output logic                  done
);

  dma_state_e            r_state;
  dma_state_e            w_state_nxt;
  logic [LEN_W-1:0]      r_cnt;
  logic [MCD_DEST_W-1:0] r_dest;
  logic [15:0]           r_dat;
  logic                  r_req;
  logic                  r_ce_wram;
  logic                  r_ce_prg;
  logic                  r_ce_pcm;
  logic                  r_we;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_W-1:0]     w_addr;
  logic                  w_kick;
  logic                  w_take;
  logic                  w_step;
  logic                  w_req_nxt;
  logic                  w_ce_wram_nxt;
  logic                  w_ce_prg_nxt;
  logic                  w_ce_pcm_nxt;
  logic                  w_we_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_unused_dbc0;

  // Byte count is in bytes; only whole words are moved.
  assign w_unused_dbc0 = dbc[0];

  // stop overrides everything, including a simultaneous start in IDLE.
  assign w_kick = (r_state == ST_IDLE)  && start && !stop;
  assign w_take = (r_state == ST_FETCH) && buf_rd_ack && !stop;
  assign w_step = (r_state == ST_NEXT)  && !stop;

  mcd_dma_addr_gen #(
    .ADDR_W (ADDR_W),
    .PCM_AW (PCM_AW)
  ) u_addr_gen (
    .clk_asic   (clk_asic),
    .cd_rst     (cd_rst),
    .i_en       (sub_sync),
    .i_load     (w_kick),
    .i_inc      (w_step),
    .i_dest     (dest),
    .i_addr_reg (dma_addr_reg),
    .o_addr     (w_addr)
  );

  // State register.
  always_ff @(posedge clk_asic) begin
    if (cd_rst) begin
      r_state <= ST_IDLE;
    end else if (sub_sync) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = dst_valid(dest) ? ST_FETCH : ST_DONE;
      ST_FETCH: if (buf_rd_ack) w_state_nxt = ST_WRITE;
      ST_WRITE: if (!halt) w_state_nxt = ST_NEXT;
      ST_NEXT:  w_state_nxt = (r_cnt == LEN_W'(1)) ? ST_DONE : ST_FETCH;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (stop) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Output decode of the upcoming state; registered below so outputs track the state.
  always_comb begin
    w_req_nxt     = 1'b0;
    w_ce_wram_nxt = 1'b0;
    w_ce_prg_nxt  = 1'b0;
    w_ce_pcm_nxt  = 1'b0;
    w_we_nxt      = 1'b0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    case (w_state_nxt)
      ST_FETCH: begin
        w_req_nxt  = 1'b1;
        w_busy_nxt = 1'b1;
      end
      ST_WRITE: begin
        w_ce_wram_nxt = (r_dest == DST_WRAM);
        w_ce_prg_nxt  = (r_dest == DST_PRG);
        w_ce_pcm_nxt  = (r_dest == DST_PCM);
        w_we_nxt      = 1'b1;
        w_busy_nxt    = 1'b1;
      end
      ST_NEXT:  w_busy_nxt = 1'b1;
      ST_DONE:  w_done_nxt = 1'b1;
      default:  ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk_asic) begin
    if (cd_rst) begin
      r_req     <= 1'b0;
      r_ce_wram <= 1'b0;
      r_ce_prg  <= 1'b0;
      r_ce_pcm  <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (sub_sync) begin
      r_req     <= w_req_nxt;
      r_ce_wram <= w_ce_wram_nxt;
      r_ce_prg  <= w_ce_prg_nxt;
      r_ce_pcm  <= w_ce_pcm_nxt;
      r_we      <= w_we_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Transfer bookkeeping: destination, remaining words, write data.
  always_ff @(posedge clk_asic) begin
    if (cd_rst) begin
      r_dest <= '0;
      r_cnt  <= '0;
      r_dat  <= '0;
    end else if (sub_sync) begin
      if (w_kick) begin
        r_dest <= dest;
        r_cnt  <= {1'b0, dbc[LEN_W-1:1]} + LEN_W'(1);
      end else if (w_step) begin
        r_cnt <= r_cnt - LEN_W'(1);
      end
      if (w_take) begin
        r_dat <= buf_rd_dat;
      end
    end
  end

  assign buf_rd_req = r_req;
  assign busy       = r_busy;
  assign done       = r_done;

  always_comb begin
    dma         = '0;
    dma.ce_wram = r_ce_wram;
    dma.ce_prg  = r_ce_prg;
    dma.ce_pcm  = r_ce_pcm;
    dma.we      = r_we;
    dma.addr    = MCD_ADDR_W'(w_addr);
    dma.dat     = r_dat;
  end

endmodule

// File: tb/tb_mcd_cdc_dma.sv
// Bench for mcd_cdc_dma: directed transfers with a transfer-level expectation
// model, a per-clock comparator, and a write/done monitor pinned by literals.
module tb_mcd_cdc_dma;
  import mcd_pkg::*;

  logic        clk_asic = 1'b0;
  logic        cd_rst = 1'b0;
  logic        sub_sync = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [2:0]  dest = 3'd0;
  logic [15:0] dma_addr_reg = 16'h0;
  logic [11:0] dbc = 12'h0;
  logic        buf_rd_req;
  logic        buf_rd_ack = 1'b0;
  logic [15:0] buf_rd_dat = 16'h0;
  logic        halt = 1'b0;
  McdDma       dma;
  logic        busy;
  logic        done;

  mcd_cdc_dma dut (
    .clk_asic     (clk_asic),
    .cd_rst       (cd_rst),
    .sub_sync     (sub_sync),
    .start        (start),
    .stop         (stop),
    .dest         (dest),
    .dma_addr_reg (dma_addr_reg),
    .dbc          (dbc),
    .buf_rd_req   (buf_rd_req),
    .buf_rd_ack   (buf_rd_ack),
    .buf_rd_dat   (buf_rd_dat),
    .halt         (halt),
    .dma          (dma),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk_asic = ~clk_asic;

  // Expected outputs; ce ordering is {wram, prg, pcm}.
  logic        e_req = 1'b0;
  logic [2:0]  e_ce = 3'b000;
  logic        e_we = 1'b0;
  logic        e_busy = 1'b0;
  logic        e_done = 1'b0;
  logic [18:0] e_addr = 19'h0;
  logic [15:0] e_dat = 16'h0;
  bit          chk_en = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic is_valid(input logic [2:0] d);
    return (d == DST_WRAM) || (d == DST_PRG) || (d == DST_PCM);
  endfunction

  function automatic logic [2:0] ce_of(input logic [2:0] d);
    return {d == DST_WRAM, d == DST_PRG, d == DST_PCM};
  endfunction

  function automatic logic [18:0] start_addr(input logic [2:0] d, input logic [15:0] areg);
    if (d == DST_PCM) return 19'((32'(areg) % 4096) * 2);
    return 19'(32'(areg) * 8);
  endfunction

  function automatic logic [18:0] next_addr(input logic [2:0] d, input logic [18:0] a);
    if (d == DST_PCM) return (a & ~19'h01FFF) | 19'((32'(a) + 2) % 8192);
    return 19'((32'(a) + 2) % 524288);
  endfunction

  // Per-clock comparator, sampled on the falling edge.
  always @(negedge clk_asic) begin
    if (chk_en) begin
      chk("ctl", 64'({buf_rd_req, dma.ce_wram, dma.ce_prg, dma.ce_pcm, dma.we, busy, done}),
                 64'({e_req, e_ce, e_we, e_busy, e_done}));
      chk("addr", 64'(dma.addr), 64'(e_addr));
      chk("dat", 64'(dma.dat), 64'(e_dat));
      chk("order", 64'((buf_rd_req && (dma.ce_wram || dma.ce_prg || dma.ce_pcm)) ||
                       ($countones({dma.ce_wram, dma.ce_prg, dma.ce_pcm}) > 1)), 64'(0));
    end
  end

  // Monitor: committed writes, done pulses, sub_sync tick index.
  logic [34:0] wr_q[$];
  int n_done = 0;
  int tick_cnt = 0;
  int done_tick = 0;
  always @(posedge clk_asic) begin
    if (sub_sync && !cd_rst) begin
      if ((dma.ce_wram || dma.ce_prg || dma.ce_pcm) && !halt) wr_q.push_back({dma.addr, dma.dat});
      if (done) begin
        n_done++;
        done_tick = tick_cnt;
      end
      tick_cnt++;
    end
  end

  // One idle clock with sub_sync low, then one enabled clock.
  task automatic tick();
    @(posedge clk_asic);
    #1 sub_sync = 1'b1;
    @(posedge clk_asic);
    #1 sub_sync = 1'b0;
  endtask

  task automatic chk_wr(input string nm, input int idx, input logic [18:0] a, input logic [15:0] d);
    logic [34:0] got;
    got = (idx < wr_q.size()) ? wr_q[idx] : '1;
    chk(nm, 64'(got), 64'({a, d}));
  endtask

  // Transfer-level model: word k goes to start+2k (wrapped) with data base+k.
  task automatic run_xfer(input logic [2:0] d, input logic [15:0] areg, input logic [11:0] cm1,
                          input logic [15:0] base, input int halt_word, input int halt_n,
                          input int stop_word, input int busy_start_word);
    int n;
    logic [18:0] a;
    n = int'(cm1[11:1]) + 1;
    a = start_addr(d, areg);
    dest = d; dma_addr_reg = areg; dbc = cm1; start = 1'b1;
    tick();
    start = 1'b0; dest = 3'd0; dma_addr_reg = 16'hFFFF; dbc = 12'hFFF;
    e_addr = a;
    if (!is_valid(d)) begin
      e_done = 1'b1;
      tick();
      e_done = 1'b0;
      return;
    end
    e_req = 1'b1; e_busy = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k == stop_word) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
        e_req = 1'b0; e_busy = 1'b0;
        return;
      end
      if (k == busy_start_word) begin
        start = 1'b1; dest = DST_PRG; dma_addr_reg = 16'h1234; dbc = 12'h0FF;
        tick();
        start = 1'b0;
      end
      buf_rd_ack = 1'b1; buf_rd_dat = base + 16'(k);
      tick();
      buf_rd_ack = 1'b0; buf_rd_dat = 16'hDEAD;
      e_req = 1'b0; e_ce = ce_of(d); e_we = 1'b1; e_dat = base + 16'(k);
      if (k == halt_word) begin
        halt = 1'b1;
        repeat (halt_n) tick();
        halt = 1'b0;
      end
      tick();
      e_ce = 3'b000; e_we = 1'b0;
      tick();
      a = next_addr(d, a);
      e_addr = a;
      if (k == n - 1) begin
        e_busy = 1'b0; e_done = 1'b1;
      end else begin
        e_req = 1'b1;
      end
    end
    tick();
    e_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int nd0;
    int s;

    // Reset
    cd_rst = 1'b1;
    repeat (2) @(posedge clk_asic);
    #1 cd_rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // 1: WRAM, 3 words, immediate ack
    wr_q.delete(); nd0 = n_done; s = tick_cnt;
    run_xfer(DST_WRAM, 16'h0010, 12'd5, 16'hA000, -1, 0, -1, -1);
    chk("t1_nwr", 64'(wr_q.size()), 64'(3));
    chk_wr("t1_w0", 0, 19'h00080, 16'hA000);
    chk_wr("t1_w1", 1, 19'h00082, 16'hA001);
    chk_wr("t1_w2", 2, 19'h00084, 16'hA002);
    chk("t1_done", 64'(n_done - nd0), 64'(1));
    chk("t1_lat", 64'(done_tick - s), 64'(10));

    // 2: same with 4-tick halt on the second write
    wr_q.delete(); nd0 = n_done; s = tick_cnt;
    run_xfer(DST_WRAM, 16'h0010, 12'd5, 16'hB000, 1, 4, -1, -1);
    chk("t2_nwr", 64'(wr_q.size()), 64'(3));
    chk_wr("t2_w1", 1, 19'h00082, 16'hB001);
    chk_wr("t2_w2", 2, 19'h00084, 16'hB002);
    chk("t2_done", 64'(n_done - nd0), 64'(1));
    chk("t2_lat", 64'(done_tick - s), 64'(14));

    // 3: PCM wrap at 8 KB
    wr_q.delete();
    run_xfer(DST_PCM, 16'h0FFF, 12'd3, 16'hC000, -1, 0, -1, -1);
    chk("t3_nwr", 64'(wr_q.size()), 64'(2));
    chk_wr("t3_w0", 0, 19'h01FFE, 16'hC000);
    chk_wr("t3_w1", 1, 19'h00000, 16'hC001);

    // 4: stop during second fetch, then a fresh transfer
    wr_q.delete(); nd0 = n_done;
    run_xfer(DST_PRG, 16'h0200, 12'd7, 16'hD000, -1, 0, 1, -1);
    repeat (3) tick();
    chk("t4_nwr", 64'(wr_q.size()), 64'(1));
    chk_wr("t4_w0", 0, 19'h01000, 16'hD000);
    chk("t4_nodone", 64'(n_done - nd0), 64'(0));
    wr_q.delete();
    run_xfer(DST_PRG, 16'h0040, 12'd1, 16'hD100, -1, 0, -1, -1);
    chk_wr("t4_restart", 0, 19'h00200, 16'hD100);
    chk("t4_done", 64'(n_done - nd0), 64'(1));

    // 5a: start while busy is ignored; also wraps at the top of WRAM/PRG space
    wr_q.delete();
    run_xfer(DST_WRAM, 16'hFFFF, 12'd7, 16'hE000, -1, 0, -1, 1);
    chk("t5_nwr", 64'(wr_q.size()), 64'(4));
    chk_wr("t5_w1", 1, 19'h7FFFA, 16'hE001);
    chk_wr("t5_w3", 3, 19'h7FFFE, 16'hE003);

    // 5b: invalid destination: done pulse, no write
    wr_q.delete(); nd0 = n_done;
    run_xfer(3'd2, 16'h0030, 12'd3, 16'hF000, -1, 0, -1, -1);
    chk("t5b_nwr", 64'(wr_q.size()), 64'(0));
    chk("t5b_done", 64'(n_done - nd0), 64'(1));

    // 5c: start and stop together in IDLE: stop wins
    nd0 = n_done;
    start = 1'b1; stop = 1'b1; dest = DST_WRAM; dma_addr_reg = 16'h0777;
    tick();
    start = 1'b0; stop = 1'b0;
    repeat (3) tick();
    chk("t5c_nwr", 64'(wr_q.size()), 64'(0));
    chk("t5c_nodone", 64'(n_done - nd0), 64'(0));

    // 6: reset in WRITE, then a late ack
    wr_q.delete();
    dest = DST_WRAM; dma_addr_reg = 16'h0100; dbc = 12'd3; start = 1'b1;
    tick();
    start = 1'b0;
    e_addr = 19'h00800; e_req = 1'b1; e_busy = 1'b1;
    buf_rd_ack = 1'b1; buf_rd_dat = 16'h5A5A;
    tick();
    buf_rd_ack = 1'b0;
    e_req = 1'b0; e_ce = 3'b100; e_we = 1'b1; e_dat = 16'h5A5A;
    halt = 1'b1;
    tick();
    cd_rst = 1'b1;
    @(posedge clk_asic);
    #1 cd_rst = 1'b0;
    halt = 1'b0;
    e_ce = 3'b000; e_we = 1'b0; e_busy = 1'b0; e_addr = 19'h0; e_dat = 16'h0;
    buf_rd_ack = 1'b1; buf_rd_dat = 16'hBEEF;
    tick();
    buf_rd_ack = 1'b0;
    repeat (3) tick();
    chk("t6_nwr", 64'(wr_q.size()), 64'(0));

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
